vscale_alu_src_arbiter: RTL



---
 rtl/vscale_alu_src_arbiter_pkg.sv | 41 ++++
 rtl/vscale_alu_src_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vscale_alu_src_arbiter_pkg.sv
// Shared constants for the execute-stage operand-A arbiter.
// Holds the operand-A select encodings (including the auxiliary code),
// the arbiter state encoding and the counter widths used by
// vscale_alu_src_arbiter.
package vscale_alu_src_arbiter_pkg;

  // Width of the operand-A select code driven to the operand-A mux.
  localparam int SRC_A_SEL_WIDTH = 2;

  // Existing pipeline operand-A selects.
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_RS1  = 2'd0;
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_PC   = 2'd1;
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_ZERO = 2'd2;

  // Auxiliary operand select; takes the one code the pipeline never uses.
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_AUX  = 2'd3;

  // Counter widths: beats per burst (aux_len + 1, up to 16) and
  // refused-request cycles (MAX_WAIT up to 255).
  localparam int BEAT_CNT_WIDTH = 4;
  localparam int WAIT_CNT_WIDTH = 8;

  // Arbiter ownership state: IDLE = pipeline owns the ALU,
  // GRANT = auxiliary requester owns the ALU for a burst.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Saturating increment of the refused-request counter.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_sat_inc(
    input logic [WAIT_CNT_WIDTH-1:0] cnt,
    input logic [WAIT_CNT_WIDTH-1:0] max_cnt
  );
    if (cnt >= max_cnt) begin
      return max_cnt;
    end
    return cnt + {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/vscale_alu_src_arbiter.sv
// Operand-A arbiter between the DX pipeline stage and the auxiliary
// (AMO/CSR helper) sequencer.
//
// Optional feature macro: VSCALE_ALU_ARB_STARVE_EN
//   defined   -> a refused-request counter forces the pipeline to yield
//                once the auxiliary request has waited MAX_WAIT cycles.
//   undefined -> strict pipeline priority; the counter is absent and
//                MAX_WAIT is accepted but unused.
//
// Handshake: aux_req is a level held high by the requester for the whole
// burst. A decision is taken in an IDLE cycle (the pipeline op of that
// cycle still executes); beats start the following cycle. Every GRANT
// cycle with aux_req high is one beat (aux_grant = 1), aux_last marks the
// final one. Dropping aux_req in GRANT aborts the burst: that cycle is not
// a beat and the block is IDLE on the next cycle. A reset during a burst
// is also an abort (no aux_last is ever shown for it).
//
// All outputs are combinational from registered state plus dx_valid,
// dx_src_a_sel and aux_req; aux_len only feeds the beat counter.
module vscale_alu_src_arbiter
  import vscale_alu_src_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dx_valid,
  input  logic [SRC_A_SEL_WIDTH-1:0] dx_src_a_sel,
  input  logic                       aux_req,
  input  logic [BEAT_CNT_WIDTH-1:0]  aux_len,
  output logic [SRC_A_SEL_WIDTH-1:0] alu_src_a_sel,
  output logic                       aux_grant,
  output logic                       aux_last,
  output logic                       dx_stall,
  output arb_state_e                 dbg_state
);

  arb_state_e                state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  // High when the auxiliary request may override a valid pipeline op.
  logic force_yield;

  // IDLE-cycle grant decision; shared by the FSM and the wait counter.
  logic grant_decide;

  assign grant_decide = (state_q == ARB_IDLE) && aux_req &&
                        (!dx_valid || force_yield);

`ifdef VSCALE_ALU_ARB_STARVE_EN
  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  assign force_yield = (wait_cnt_q == MAX_WAIT_C);

  // Count cycles an auxiliary request is refused by a busy pipeline;
  // cleared on a grant decision or when the request goes away.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_decide) begin
      wait_cnt_d = '0;
    end else if (state_q == ARB_IDLE) begin
      if (aux_req && dx_valid) begin
        wait_cnt_d = wait_sat_inc(wait_cnt_q, MAX_WAIT_C);
      end else if (!aux_req) begin
        wait_cnt_d = '0;
      end
    end
  end

  // Refused-request counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Strict pipeline priority: a valid DX op always wins.
  assign force_yield = 1'b0;

  // MAX_WAIT has no function in this build; tie it off explicitly.
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  // Next-state, beat counting and output decode for the ownership FSM.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    alu_src_a_sel = dx_src_a_sel;
    aux_grant     = 1'b0;
    aux_last      = 1'b0;
    dx_stall      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Pipeline owns the ALU; its op this cycle executes normally.
        if (grant_decide) begin
          state_d    = ARB_GRANT;
          beat_cnt_d = aux_len;
        end
      end

      ARB_GRANT: begin
        alu_src_a_sel = SRC_A_AUX;
        aux_grant     = aux_req;
        aux_last      = aux_req && (beat_cnt_q == '0);
        dx_stall      = dx_valid;
        if (!aux_req) begin
          // Abort: not a beat, hand the ALU back next cycle.
          state_d = ARB_IDLE;
        end else if (beat_cnt_q == '0) begin
          // Final beat; the mandatory IDLE cycle follows.
          state_d = ARB_IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q - {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule
